// File: rtl/calc_exec_ctrl_if.sv
// Keypad-calculator execution bus: decoded operands in, BCD result and status out.
interface calc_exec_ctrl_if;
    localparam int unsigned DIG_W = 4;

    logic             exec;
    logic [DIG_W-1:0] n1;
    logic [DIG_W-1:0] op;
    logic [DIG_W-1:0] n2;
    logic             busy;
    logic             done;
    logic             valid;
    logic             err;
    logic             neg;
    logic [DIG_W-1:0] tens;
    logic [DIG_W-1:0] units;

    modport master (
        output exec, n1, op, n2,
        input  busy, done, valid, err, neg, tens, units
    );

    modport slave (
        input  exec, n1, op, n2,
        output busy, done, valid, err, neg, tens, units
    );
endinterface

// File: rtl/calc_exec_ctrl.sv
// Execution sequencer for the keypad calculator: captures N1/OP/N2 on exec,
// runs add/sub/mul (mul by repeated addition) on a shared accumulator, then
// splits the result into BCD tens/units by repeated subtraction of 10.
// Optional feature macro: CALC_DIV_EN (op 15 = integer divide).
module calc_exec_ctrl #(
    parameter int unsigned ACC_W      = 7,
    parameter bit          START_EDGE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    calc_exec_ctrl_if.slave bus
);
    localparam int unsigned DIG_W = 4;

`ifdef CALC_DIV_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ADD, S_SUB, S_MUL, S_BCD, S_DONE, S_DIV
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ADD, S_SUB, S_MUL, S_BCD, S_DONE
    } state_t;
`endif

    state_t             state_q, state_d;
    logic               exec_q, exec_d;
    logic               prime_q, prime_d;
    logic [DIG_W-1:0]   a_q, a_d, b_q, b_d, op_q, op_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DIG_W-1:0]   cnt_q, cnt_d, t_q, t_d;
    logic               neg_i_q, neg_i_d, err_pend_q, err_pend_d;
    logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic               err_q, err_d, neg_q, neg_d;
    logic [DIG_W-1:0]   tens_q, tens_d, units_q, units_d;
`ifdef CALC_DIV_EN
    logic [ACC_W-1:0]   quo_q, quo_d;
`endif
    logic               start_c;
    logic               op_ok_c;

    // Start qualifier; the first cycle after reset only primes the exec history
    // so an exec already high at reset release is not mistaken for a rising edge.
    assign start_c = START_EDGE ? (bus.exec & ~exec_q & prime_q) : bus.exec;

    // Supported opcode check for the captured operation.
`ifdef CALC_DIV_EN
    assign op_ok_c = (op_q == 4'd10) || (op_q == 4'd11) || (op_q == 4'd12) ||
                     ((op_q == 4'd15) && (b_q != 4'd0));
`else
    assign op_ok_c = (op_q == 4'd10) || (op_q == 4'd11) || (op_q == 4'd12);
`endif

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        exec_d     = bus.exec;
        prime_d    = 1'b1;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        t_d        = t_q;
        neg_i_d    = neg_i_q;
        err_pend_d = err_pend_q;
        valid_d    = valid_q;
        err_d      = err_q;
        neg_d      = neg_q;
        tens_d     = tens_q;
        units_d    = units_q;
`ifdef CALC_DIV_EN
        quo_d      = quo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_LOAD;
                    a_d     = bus.n1;
                    op_d    = bus.op;
                    b_d     = bus.n2;
                    valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                t_d     = '0;
                neg_i_d = 1'b0;
                if ((a_q > 4'd9) || (b_q > 4'd9) || !op_ok_c) begin
                    err_pend_d = 1'b1;
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    valid_d    = 1'b0;
                    neg_d      = 1'b0;
                    tens_d     = '0;
                    units_d    = '0;
                end else begin
                    err_pend_d = 1'b0;
                    if (op_q == 4'd10) begin
                        state_d = S_ADD;
                    end else if (op_q == 4'd11) begin
                        state_d = S_SUB;
                    end else if (op_q == 4'd12) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        cnt_d   = b_q;
                    end else begin
`ifdef CALC_DIV_EN
                        state_d = S_DIV;
                        acc_d   = ACC_W'(a_q);
                        quo_d   = '0;
`endif
                    end
                end
            end
            S_ADD: begin
                acc_d   = ACC_W'(a_q) + ACC_W'(b_q);
                neg_i_d = 1'b0;
                state_d = S_BCD;
            end
            S_SUB: begin
                if (a_q >= b_q) begin
                    acc_d   = ACC_W'(a_q) - ACC_W'(b_q);
                    neg_i_d = 1'b0;
                end else begin
                    acc_d   = ACC_W'(b_q) - ACC_W'(a_q);
                    neg_i_d = 1'b1;
                end
                state_d = S_BCD;
            end
            S_MUL: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_BCD;
                end else begin
                    acc_d = acc_q + ACC_W'(a_q);
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef CALC_DIV_EN
            S_DIV: begin
                if (acc_q >= ACC_W'(b_q)) begin
                    acc_d = acc_q - ACC_W'(b_q);
                    quo_d = quo_q + ACC_W'(1);
                end else begin
                    acc_d   = quo_q;
                    state_d = S_BCD;
                end
            end
`endif
            S_BCD: begin
                if (acc_q >= ACC_W'(10)) begin
                    acc_d = acc_q - ACC_W'(10);
                    t_d   = t_q + 4'd1;
                end else begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    neg_d   = neg_i_q;
                    tens_d  = t_q;
                    units_d = acc_q[DIG_W-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            exec_q     <= 1'b0;
            prime_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            t_q        <= '0;
            neg_i_q    <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            neg_q      <= 1'b0;
            tens_q     <= '0;
            units_q    <= '0;
`ifdef CALC_DIV_EN
            quo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            exec_q     <= exec_d;
            prime_q    <= prime_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            t_q        <= t_d;
            neg_i_q    <= neg_i_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            neg_q      <= neg_d;
            tens_q     <= tens_d;
            units_q    <= units_d;
`ifdef CALC_DIV_EN
            quo_q      <= quo_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.neg   = neg_q;
    assign bus.tens  = tens_q;
    assign bus.units = units_q;
endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Directed bench for calc_exec_ctrl: vector table plus hand-written
// held-exec and mid-operation reset sequences.
module tb_calc_exec_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    calc_exec_ctrl_if bus();

    calc_exec_ctrl #(
        .ACC_W      (7),
        .START_EDGE (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] n1;
        logic [3:0] op;
        logic [3:0] n2;
        int         tens;
        int         units;
        int         neg;
        int         err;
        int         lat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise exec from low, then count edges after the start-sampling edge until done.
    task automatic run_op(input logic [3:0] a, input logic [3:0] o, input logic [3:0] b,
                          input string tag, output int lat);
        @(negedge clk);
        bus.exec = 1'b0;
        bus.n1   = a;
        bus.op   = o;
        bus.n2   = b;
        @(negedge clk);
        bus.exec = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_load_busy"}, int'(bus.busy), 1);
        check({tag, "_load_valid"}, int'(bus.valid), 0);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_valid"}, int'(bus.valid), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_neg"}, int'(bus.neg), 0);
        check({tag, "_tens"}, int'(bus.tens), 0);
        check({tag, "_units"}, int'(bus.units), 0);
    endtask

    initial begin
        int    lat;
        int    cnt;
        string tag;

        //             n1    op     n2    tens units neg err lat
        vecs.push_back('{4'd2, 4'd10, 4'd3, 0, 5, 0, 0, 3});
        vecs.push_back('{4'd3, 4'd11, 4'd8, 0, 5, 1, 0, 3});
        vecs.push_back('{4'd2, 4'd13, 4'd3, 0, 0, 0, 1, 1});
        vecs.push_back('{4'd0, 4'd12, 4'd0, 0, 0, 0, 0, 3});
        vecs.push_back('{4'd7, 4'd10, 4'd9, 1, 6, 0, 0, 4});
        vecs.push_back('{4'd9, 4'd11, 4'd0, 0, 9, 0, 0, 3});
        vecs.push_back('{4'd4, 4'd12, 4'd5, 2, 0, 0, 0, 10});
        vecs.push_back('{4'd0, 4'd11, 4'd9, 0, 9, 1, 0, 3});
        vecs.push_back('{4'd10, 4'd10, 4'd1, 0, 0, 0, 1, 1});
        vecs.push_back('{4'd5, 4'd11, 4'd12, 0, 0, 0, 1, 1});
        vecs.push_back('{4'd6, 4'd12, 4'd3, 1, 8, 0, 0, 7});
`ifdef CALC_DIV_EN
        vecs.push_back('{4'd9, 4'd15, 4'd2, 0, 4, 0, 0, 7});
        vecs.push_back('{4'd9, 4'd15, 4'd0, 0, 0, 0, 1, 1});
        vecs.push_back('{4'd7, 4'd15, 4'd7, 0, 1, 0, 0, 4});
`else
        vecs.push_back('{4'd9, 4'd15, 4'd2, 0, 0, 0, 1, 1});
`endif

        reset    = 1'b0;
        bus.exec = 1'b0;
        bus.n1   = '0;
        bus.op   = '0;
        bus.n2   = '0;
        #1;
        check_outputs_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            tag = $sformatf("v%0d", i);
            run_op(vecs[i].n1, vecs[i].op, vecs[i].n2, tag, lat);
            check({tag, "_lat"}, lat, vecs[i].lat);
            check({tag, "_tens"}, int'(bus.tens), vecs[i].tens);
            check({tag, "_units"}, int'(bus.units), vecs[i].units);
            check({tag, "_neg"}, int'(bus.neg), vecs[i].neg);
            check({tag, "_err"}, int'(bus.err), vecs[i].err);
            check({tag, "_valid"}, int'(bus.valid), 1 - vecs[i].err);
            check({tag, "_busy"}, int'(bus.busy), 1);
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, int'(bus.done), 0);
            check({tag, "_idle_busy"}, int'(bus.busy), 0);
            check({tag, "_hold_units"}, int'(bus.units), vecs[i].units);
        end

        // 9x9 with exec held high afterwards: exactly one done.
        run_op(4'd9, 4'd12, 4'd9, "m99", lat);
        check("m99_lat", lat, 20);
        check("m99_tens", int'(bus.tens), 8);
        check("m99_units", int'(bus.units), 1);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) cnt++;
        end
        check("held_exec_retrigger", cnt, 0);
        check("held_exec_valid", int'(bus.valid), 1);

        // 9x7, reset asserted in MUL cycle 4.
        @(negedge clk);
        bus.exec = 1'b0;
        bus.n1   = 4'd9;
        bus.op   = 4'd12;
        bus.n2   = 4'd7;
        @(negedge clk);
        bus.exec = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", int'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.done) cnt++;
        end
        check("post_rst_no_start", cnt, 0);
        run_op(4'd9, 4'd12, 4'd7, "m97", lat);
        check("m97_lat", lat, 16);
        check("m97_tens", int'(bus.tens), 6);
        check("m97_units", int'(bus.units), 3);
        check("m97_valid", int'(bus.valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
